inv_cipher_seq: RTL

INV_CIPHER_SEQ -- requirements
Module: inv_cipher_seq

---
 rtl/aes_pkg.sv | 116 +++++++++++
 rtl/inv_round.sv | 60 ++++++
 rtl/inv_cipher_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the Cipher and InvCipher datapaths.
// Holds the FSM state type, GF(2^8) arithmetic (xtime, gf_mul, gf_inv),
// the forward and inverse S-box tables, the Rcon table and the word
// helpers used by the key schedule.
// The S-box tables are built at elaboration time from the field inverse and
// the affine map, so they are constants (ROMs) in hardware.
package aes_pkg;

    localparam int unsigned BLK_W  = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned TBL_W  = 2048;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYEXP = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply (shift-and-add).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Forward S-box: field inverse followed by the affine transform.
    function automatic logic [TBL_W-1:0] build_sbox();
        logic [TBL_W-1:0] t;
        logic [7:0]       b;
        t = '0;
        for (int x = 0; x < 256; x++) begin
            b = gf_inv(8'(x));
            t[8*x +: 8] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                            ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
        return t;
    endfunction

    localparam logic [TBL_W-1:0] SBOX_TBL = build_sbox();

    // Inverse S-box by inverting the forward table.
    function automatic logic [TBL_W-1:0] build_inv_sbox();
        logic [TBL_W-1:0] t;
        logic [7:0]       s;
        t = '0;
        for (int x = 0; x < 256; x++) begin
            s = SBOX_TBL[8*x +: 8];
            t[{s, 3'b000} +: 8] = 8'(x);
        end
        return t;
    endfunction

    localparam logic [TBL_W-1:0] INV_SBOX_TBL = build_inv_sbox();

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX_TBL[{a, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return INV_SBOX_TBL[{a, 3'b000} +: 8];
    endfunction

    // Round constant Rcon[j], j = 1..10.
    function automatic logic [7:0] rcon(input logic [3:0] j);
        logic [7:0] v;
        case (j)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Byte 0 of a word sits in bits [31:24].
    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/inv_round.sv
// One combinational InvCipher round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
// Ports:
//   state_i      128-bit input state, byte 0 in [127:120]
//   rkey_i       128-bit round key, same byte order
//   mix_bypass_i 1 skips InvMixColumns (final round)
//   state_c_o    128-bit combinational result
module inv_round
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] state_i,
    input  logic [BLK_W-1:0] rkey_i,
    input  logic             mix_bypass_i,
    output logic [BLK_W-1:0] state_c_o
);

    logic [7:0] b_c  [16];
    logic [7:0] sr_c [16];
    logic [7:0] ak_c [16];
    logic [7:0] mx_c [16];

    // Byte i of the state is row i%4, column i/4.
    always_comb begin
        for (int i = 0; i < 16; i++) b_c[i] = state_i[127-8*i -: 8];
    end

    // Row r rotates right by r columns, then inverse S-box.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_c[4*c+r] = inv_sbox(b_c[4*((c+4-r)%4)+r]);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) ak_c[i] = sr_c[i] ^ rkey_i[127-8*i -: 8];
    end

    // InvMixColumns matrix rows: {0e 0b 0d 09} rotated.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mx_c[4*c+0] = gf_mul(8'h0e, ak_c[4*c+0]) ^ gf_mul(8'h0b, ak_c[4*c+1])
                        ^ gf_mul(8'h0d, ak_c[4*c+2]) ^ gf_mul(8'h09, ak_c[4*c+3]);
            mx_c[4*c+1] = gf_mul(8'h09, ak_c[4*c+0]) ^ gf_mul(8'h0e, ak_c[4*c+1])
                        ^ gf_mul(8'h0b, ak_c[4*c+2]) ^ gf_mul(8'h0d, ak_c[4*c+3]);
            mx_c[4*c+2] = gf_mul(8'h0d, ak_c[4*c+0]) ^ gf_mul(8'h09, ak_c[4*c+1])
                        ^ gf_mul(8'h0e, ak_c[4*c+2]) ^ gf_mul(8'h0b, ak_c[4*c+3]);
            mx_c[4*c+3] = gf_mul(8'h0b, ak_c[4*c+0]) ^ gf_mul(8'h0d, ak_c[4*c+1])
                        ^ gf_mul(8'h09, ak_c[4*c+2]) ^ gf_mul(8'h0e, ak_c[4*c+3]);
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            state_c_o[127-8*i -: 8] = mix_bypass_i ? ak_c[i] : mx_c[i];
        end
    end

endmodule

// File: rtl/inv_cipher_seq.sv
// Iterative AES InvCipher, one round per clock, with on-the-fly key expansion
// into a round-key store on every accepted start.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   start  request pulse, honoured only in IDLE
//   in     128-bit ciphertext, byte 0 in [127:120]
//   key    32*Nk-bit cipher key, w[0] in the top word
//   busy   high while key expansion and rounds run
//   done   one-cycle pulse when out becomes valid
//   out    128-bit plaintext, held until the next accepted start
module inv_cipher_seq
    import aes_pkg::*;
#(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BLK_W-1:0]   in,
    input  logic [32*Nk-1:0]   key,
    output logic               busy,
    output logic               done,
    output logic [BLK_W-1:0]   out
);

    localparam int unsigned NW = 4 * (Nr + 1);
    localparam int unsigned IW = $clog2(NW);
    localparam int unsigned MW = 3;
    localparam int unsigned RW = 4;

    if (!((Nk == 4 && Nr == 10) || (Nk == 6 && Nr == 12) || (Nk == 8 && Nr == 14))) begin : g_bad_param
        $fatal(1, "inv_cipher_seq: illegal (Nk,Nr) pair");
    end

    state_e            state_q, state_d;
    logic [IW-1:0]     i_q, i_d;
    logic [MW-1:0]     mod_q, mod_d;
    logic [RW-1:0]     rc_q, rc_d;
    logic [RW-1:0]     r_q, r_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BLK_W-1:0]  out_q, out_d;

    logic [BLK_W-1:0]  st_q;
    logic [WORD_W-1:0] win_q  [Nk];
    logic [WORD_W-1:0] rk_mem [NW];

    logic              accept_c, kexp_last_c, round_last_c;
    logic [WORD_W-1:0] temp_c, new_word_c;
    logic [BLK_W-1:0]  rkey_c, round_c, st_nxt_c;
    logic [IW-1:0]     rk_base_c;

    assign accept_c     = (state_q == ST_IDLE) && start;
    assign kexp_last_c  = (i_q == IW'(NW - 1));
    assign round_last_c = (r_q == '0);

    // Round key r is words 4r..4r+3 of the store.
    assign rk_base_c = IW'({r_q, 2'b00});
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rkey_c[127-32*k -: 32] = rk_mem[rk_base_c + IW'(k)];
        end
    end

    // Key schedule word: win_q[0] = w[i-Nk], win_q[Nk-1] = w[i-1].
    always_comb begin
        temp_c = win_q[Nk-1];
        if (mod_q == '0) begin
            temp_c = sub_word(rot_word(win_q[Nk-1])) ^ {rcon(rc_q), 24'h000000};
        end else if (Nk == 8 && mod_q == MW'(4)) begin
            temp_c = sub_word(win_q[Nk-1]);
        end
        new_word_c = win_q[0] ^ temp_c;
    end

    inv_round u_inv_round (
        .state_i      (st_q),
        .rkey_i       (rkey_c),
        .mix_bypass_i (round_last_c),
        .state_c_o    (round_c)
    );

    // First round step is a bare AddRoundKey with rk[Nr].
    assign st_nxt_c = (r_q == RW'(Nr)) ? (st_q ^ rkey_c) : round_c;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start)        state_d = ST_KEYEXP;
            ST_KEYEXP: if (kexp_last_c)  state_d = ST_ROUND;
            ST_ROUND:  if (round_last_c) state_d = ST_DONE;
            ST_DONE:                     state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Output and counter next values.
    always_comb begin
        i_d    = i_q;
        mod_d  = mod_q;
        rc_d   = rc_q;
        r_d    = r_q;
        out_d  = out_q;
        busy_d = (state_d == ST_KEYEXP) || (state_d == ST_ROUND);
        done_d = (state_d == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    i_d   = IW'(Nk);
                    mod_d = '0;
                    rc_d  = RW'(1);
                end
            end
            ST_KEYEXP: begin
                i_d   = i_q + 1'b1;
                mod_d = (mod_q == MW'(Nk - 1)) ? '0 : mod_q + 1'b1;
                if (mod_q == '0) rc_d = rc_q + 1'b1;
                if (kexp_last_c) r_d = RW'(Nr);
            end
            ST_ROUND: begin
                if (round_last_c) out_d = st_nxt_c;
                else              r_d   = r_q - 1'b1;
            end
            default: ;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q    <= '0;
            mod_q  <= '0;
            rc_q   <= '0;
            r_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            out_q  <= '0;
        end else begin
            i_q    <= i_d;
            mod_q  <= mod_d;
            rc_q   <= rc_d;
            r_q    <= r_d;
            busy_q <= busy_d;
            done_q <= done_d;
            out_q  <= out_d;
        end
    end

    // Datapath and round-key store; fully reloaded on each accepted start.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            st_q <= in;
            for (int k = 0; k < Nk; k++) begin
                win_q[k]  <= key[32*(Nk-k)-1 -: 32];
                rk_mem[k] <= key[32*(Nk-k)-1 -: 32];
            end
        end else if (state_q == ST_KEYEXP) begin
            for (int k = 0; k < Nk - 1; k++) win_q[k] <= win_q[k+1];
            win_q[Nk-1]  <= new_word_c;
            rk_mem[i_q]  <= new_word_c;
        end else if (state_q == ST_ROUND) begin
            st_q <= st_nxt_c;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule
